// File: rtl/cosine_job_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : cosine_job_sequencer
//  Purpose  : Upstream sequencer and result collector for the cosine-
//             similarity core. Packs a byte stream (N_ELEM A elements, then
//             N_ELEM B elements) into the core's vector inputs, reset-cycles
//             the core, pulses start, waits for done or timeout and presents
//             the 16-bit result on a valid/ready interface.
//  Ports    : clk, reset          - clock, asynchronous active-high reset
//             in_valid/in_ready/in_data    - byte input handshake
//             core_rst_n, core_start       - core control
//             core_A_vec, core_B_vec       - packed element vectors
//             core_done, core_result       - core completion / result
//             res_valid/res_ready/res_data - result handshake
//             res_timeout, res_sat         - result status flags
//             busy                         - sequencer not idle
//  Revision : 1.0 - initial release
// ============================================================================
module cosine_job_sequencer #(
    parameter int N_ELEM       = 4,
    parameter int MAX_ELEM     = 31,
    parameter int CORE_RST_CYC = 2,
    parameter int TIMEOUT_CYC  = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [7:0]          in_data,
    output logic                core_rst_n,
    output logic                core_start,
    output logic [8*N_ELEM-1:0] core_A_vec,
    output logic [8*N_ELEM-1:0] core_B_vec,
    input  logic                core_done,
    input  logic [15:0]         core_result,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [15:0]         res_data,
    output logic                res_timeout,
    output logic                res_sat,
    output logic                busy
);

    localparam int VEC_W  = 8 * N_ELEM;
    localparam int CNT_W  = $clog2(2 * N_ELEM);
    localparam int TMO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int CRST_W = $clog2(CORE_RST_CYC + 1);

    localparam logic [7:0] c_max_elem = 8'(MAX_ELEM);

    localparam logic [2:0] c_idle   = 3'd0;
    localparam logic [2:0] c_crst   = 3'd1;
    localparam logic [2:0] c_start  = 3'd2;
    localparam logic [2:0] c_wait   = 3'd3;
    localparam logic [2:0] c_result = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CRST_W-1:0] crst_q;
    logic [TMO_W-1:0]  tcnt_q;
    logic [VEC_W-1:0]  a_vec_q, b_vec_q;
    logic [15:0]       res_data_q;
    logic              res_timeout_q;
    logic              res_sat_q;

    logic       w_accept;
    logic       w_last_byte;
    logic       w_crst_done;
    logic       w_tmo;
    logic       w_clamp;
    logic [7:0] w_elem;

    assign w_accept    = in_valid && (state_q == c_idle);
    assign w_last_byte = (cnt_q == CNT_W'(2 * N_ELEM - 1));
    assign w_crst_done = (crst_q == CRST_W'(CORE_RST_CYC - 1));
    // Counter is 0 in the first WAIT cycle; its incremented value reaching
    // TIMEOUT_CYC-1 puts RESULT exactly TIMEOUT_CYC cycles after start.
    assign w_tmo       = (tcnt_q >= TMO_W'(TIMEOUT_CYC - 2));
    assign w_clamp     = (in_data > c_max_elem);
    assign w_elem      = w_clamp ? c_max_elem : in_data;

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= c_idle;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_idle:   if (w_accept && w_last_byte) state_d = c_crst;
            c_crst:   if (w_crst_done)             state_d = c_start;
            c_start:                               state_d = c_wait;
            c_wait:   if (core_done || w_tmo)      state_d = c_result;
            c_result: if (res_ready)               state_d = c_idle;
            default:                               state_d = c_idle;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        in_ready   = (state_q == c_idle);
        busy       = (state_q != c_idle);
        core_start = (state_q == c_start);
        res_valid  = (state_q == c_result);
        // Held low straight from the reset input so the core is reset
        // whenever this block is.
        core_rst_n = !reset && (state_q != c_crst);
    end

    assign core_A_vec  = a_vec_q;
    assign core_B_vec  = b_vec_q;
    assign res_data    = res_data_q;
    assign res_timeout = res_timeout_q;
    assign res_sat     = res_sat_q;

    // ---------------- datapath ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q         <= '0;
            crst_q        <= '0;
            tcnt_q        <= '0;
            a_vec_q       <= '0;
            b_vec_q       <= '0;
            res_data_q    <= '0;
            res_timeout_q <= 1'b0;
            res_sat_q     <= 1'b0;
        end else begin
            case (state_q)
                c_idle: begin
                    crst_q <= '0;
                    if (w_accept) begin
                        for (int i = 0; i < N_ELEM; i++) begin
                            if (cnt_q == CNT_W'(i))          a_vec_q[8*i +: 8] <= w_elem;
                            if (cnt_q == CNT_W'(i + N_ELEM)) b_vec_q[8*i +: 8] <= w_elem;
                        end
                        res_sat_q <= res_sat_q || w_clamp;
                        cnt_q     <= w_last_byte ? '0 : cnt_q + 1'b1;
                    end
                end
                c_crst: begin
                    crst_q <= crst_q + 1'b1;
                end
                c_start: begin
                    tcnt_q <= '0;
                end
                c_wait: begin
                    if (tcnt_q != TMO_W'(TIMEOUT_CYC)) begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                    // done has priority over a coincident timeout
                    if (core_done) begin
                        res_data_q    <= core_result;
                        res_timeout_q <= 1'b0;
                    end else if (w_tmo) begin
                        res_data_q    <= 16'h0000;
                        res_timeout_q <= 1'b1;
                    end
                end
                c_result: begin
                    if (res_ready) begin
                        res_sat_q <= 1'b0;
                    end
                end
                default: begin
                    cnt_q <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
